// File: rtl/output_struct_unpacker_pkg.sv
// Shared types for the output_struct debug link: the struct layout, frame
// geometry, unpacker state encoding and the frame checksum helper.
package output_struct_package;

    typedef struct packed {
        logic            LdA;
        logic            LdB;
        logic            LdC;
        logic            LdD;
        logic [7:0]      PC;
        logic [15:0]     addressBus;
        logic [15:0]     dataBus;
        logic [31:0]     instr;
        logic [3:0][31:0] regs;
        logic [8:0]      flags;
    } output_struct;

    localparam int unsigned OUTPUT_STRUCT_W    = $bits(output_struct);
    localparam int unsigned SNAP_PAYLOAD_BYTES = 27;
    localparam int unsigned SNAP_PAD_BITS      = 3;

    typedef enum logic [1:0] {HUNT, PAY, CHK, HOLD} unpack_state_t;

    // Two's-complement checksum byte: payload bytes plus this byte sum to zero.
    function automatic logic [7:0] snap_checksum(input logic [215:0] payload);
        logic [7:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < SNAP_PAYLOAD_BYTES; i++) begin
            sum = sum + payload[8*i +: 8];
        end
        return 8'h00 - sum;
    endfunction

endpackage

// File: rtl/output_struct_unpacker_timer.sv
// Inter-byte idle timer: counts enabled, uncleared cycles and pulses expire
// on the TIMEOUT_CYCLES-th consecutive one. Clear always wins over expiry.
module frame_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and expiry pulse.
    always_comb begin
        count_d = count_q;
        expire  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                expire  = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/output_struct_unpacker.sv
// Receiving end of the output_struct debug link: hunts for SYNC, collects
// 27 payload bytes plus checksum, and presents good snapshots on a
// valid/ready handshake.
module output_struct_unpacker
    import output_struct_package::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output output_struct snap,
    output logic         snap_valid,
    input  logic         snap_ready,
    output logic         frame_err,
    output logic [15:0]  frame_count
);

    localparam logic [4:0] LAST_BYTE = 5'(SNAP_PAYLOAD_BYTES - 1);

    unpack_state_t state_q, state_d;
    logic [215:0]  shift_q, shift_d;
    logic [7:0]    sum_q, sum_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    output_struct  snap_q, snap_d;
    logic          snap_valid_q, snap_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          rx_ready_q, rx_ready_d;

    logic          accept;
    logic          in_frame;
    logic          timeout;
    logic [7:0]    sum_total;
    logic          chk_good;

    assign accept    = rx_valid && rx_ready_q;
    assign in_frame  = (state_q == PAY) || (state_q == CHK);
    assign sum_total = sum_q + rx_data;
    assign chk_good  = (sum_total == 8'h00) && (shift_q[215 -: SNAP_PAD_BITS] == '0);

    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept || !in_frame),
        .enable (in_frame),
        .expire (timeout)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HUNT;
            shift_q       <= '0;
            sum_q         <= '0;
            byte_cnt_q    <= '0;
            snap_q        <= '0;
            snap_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            rx_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            sum_q         <= sum_d;
            byte_cnt_q    <= byte_cnt_d;
            snap_q        <= snap_d;
            snap_valid_q  <= snap_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            rx_ready_q    <= rx_ready_d;
        end
    end

    // Next-state logic; SYNC inside a frame is ordinary data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: if (accept && rx_data == SYNC_BYTE) state_d = PAY;
            PAY: begin
                if (timeout)                              state_d = HUNT;
                else if (accept && byte_cnt_q == LAST_BYTE) state_d = CHK;
            end
            CHK: begin
                if (timeout)     state_d = HUNT;
                else if (accept) state_d = chk_good ? HOLD : HUNT;
            end
            HOLD: if (snap_valid_q && snap_ready) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Datapath and output updates.
    always_comb begin
        shift_d       = shift_q;
        sum_d         = sum_q;
        byte_cnt_d    = byte_cnt_q;
        snap_d        = snap_q;
        snap_valid_d  = snap_valid_q;
        frame_count_d = frame_count_q;
        frame_err_d   = timeout;
        rx_ready_d    = (state_d != HOLD);
        case (state_q)
            HUNT: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    byte_cnt_d = '0;
                    sum_d      = '0;
                end
            end
            PAY: begin
                if (accept) begin
                    shift_d    = {shift_q[207:0], rx_data};
                    sum_d      = sum_total;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            CHK: begin
                if (accept) begin
                    if (chk_good) begin
                        snap_d        = shift_q[OUTPUT_STRUCT_W-1:0];
                        snap_valid_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (snap_valid_q && snap_ready) snap_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign rx_ready    = rx_ready_q;
    assign snap        = snap_q;
    assign snap_valid  = snap_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_output_struct_unpacker.sv
// Self-checking bench for output_struct_unpacker: table vectors, directed
// multi-cycle sequences and randomized frames against a frame-level model.
module tb_output_struct_unpacker;
    import output_struct_package::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    output_struct snap;
    logic         snap_valid;
    logic         snap_ready;
    logic         frame_err;
    logic [15:0]  frame_count;

    always #5 clock = ~clock;

    output_struct_unpacker #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .snap        (snap),
        .snap_valid  (snap_valid),
        .snap_ready  (snap_ready),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    output_struct got_q[$];
    logic [7:0]   frame_q[$];

    // Model state
    logic [15:0]  exp_fc;
    logic [212:0] last_good;

    typedef struct {
        logic [212:0] data;
        logic [2:0]   pad;
        logic [7:0]   delta;
        bit           exp_good;
    } vec_t;
    vec_t vecs[6];

    // Observe handshakes and error pulses on the pre-edge values.
    always @(posedge clock) begin
        if (!reset) begin
            if (snap_valid && snap_ready) got_q.push_back(snap);
            if (frame_err) err_pulses++;
        end
    end

    task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame = SYNC, payload {pad,data} MSB byte first, checksum adjusted by delta.
    task automatic build_frame(input logic [212:0] data, input logic [2:0] pad, input logic [7:0] delta);
        logic [215:0] p;
        logic [7:0]   s;
        logic [7:0]   b;
        p = {pad, data};
        s = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        for (int i = 0; i < 27; i++) begin
            b = p[215 - 8*i -: 8];
            frame_q.push_back(b);
            s = s + b;
        end
        frame_q.push_back(8'h00 - s + delta);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget = 0;
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 200) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: got 0 expected 1");
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap_max);
        for (int i = lo; i <= hi; i++) begin
            send_byte(frame_q[i]);
            if (gap_max > 0 && i != hi) repeat ($urandom_range(0, gap_max)) @(posedge clock);
        end
    endtask

    task automatic post_frame_checks(input logic [212:0] data, input bit exp_good, input int e0);
        output_struct got;
        repeat (3) @(posedge clock);
        #1;
        check("err_pulse_count", err_pulses - e0, exp_good ? 1'b0 : 1'b1);
        check("snap_count", got_q.size(), exp_good ? 1'b1 : 1'b0);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            check("snap_data", got, data);
        end
        got_q.delete();
        check("snap_hold", snap, last_good);
        check("snap_valid_fall", snap_valid, 1'b0);
        check("rx_ready_idle", rx_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [212:0] data, input logic [2:0] pad,
                             input logic [7:0] delta, input bit exp_good, input int gap_max);
        int e0;
        e0 = err_pulses;
        build_frame(data, pad, delta);
        send_range(0, 28, gap_max);
        if (exp_good) begin
            exp_fc    = exp_fc + 1'b1;
            last_good = data;
        end
        check("snap_valid_latency", snap_valid, exp_good);
        check("frame_err_pulse", frame_err, !exp_good);
        check("frame_count", frame_count, exp_fc);
        post_frame_checks(data, exp_good, e0);
    endtask

    function automatic logic [212:0] rand_data();
        logic [223:0] r;
        for (int k = 0; k < 7; k++) r[32*k +: 32] = $urandom;
        return r[212:0];
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        output_struct s;
        logic [212:0] d;
        logic [2:0]   pad;
        logic [7:0]   delta;
        int           e0;
        int           bad;
        int           mode;

        vecs[0] = '{data: '0,                      pad: 3'b000, delta: 8'h00, exp_good: 1'b1};
        vecs[1] = '{data: '1,                      pad: 3'b000, delta: 8'h00, exp_good: 1'b1};
        vecs[2] = '{data: {71{3'b101}},            pad: 3'b000, delta: 8'h01, exp_good: 1'b0};
        vecs[3] = '{data: {{26{8'hA5}}, 5'h05},    pad: 3'b000, delta: 8'h00, exp_good: 1'b1};
        vecs[4] = '{data: '1,                      pad: 3'b100, delta: 8'h00, exp_good: 1'b0};
        vecs[5] = '{data: '0,                      pad: 3'b000, delta: 8'hFF, exp_good: 1'b0};

        exp_fc     = '0;
        last_good  = '0;
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        snap_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_rx_ready", rx_ready, 1'b1);
        check("reset_snap", snap, '0);
        check("reset_snap_valid", snap_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_frame_count", frame_count, 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        // Good frame with named fields
        s = '0;
        s.LdA = 1'b1;
        s.PC = 8'h3C;
        s.addressBus = 16'h1234;
        run_frame(s, 3'b000, 8'h00, 1'b1, 0);
        check("field_LdA", snap.LdA, 1'b1);
        check("field_PC", snap.PC, 8'h3C);
        check("field_addressBus", snap.addressBus, 16'h1234);
        check("first_frame_count", frame_count, 16'd1);

        // Garbage in HUNT then a good frame
        e0 = err_pulses;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        run_frame(rand_data(), 3'b000, 8'h00, 1'b1, 0);
        check("garbage_no_err", err_pulses - e0, 0);

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].data, vecs[v].pad, vecs[v].delta, vecs[v].exp_good, 0);
        end

        // Backpressure
        d = rand_data();
        @(negedge clock);
        snap_ready = 1'b0;
        build_frame(d, 3'b000, 8'h00);
        send_range(0, 28, 0);
        exp_fc    = exp_fc + 1'b1;
        last_good = d;
        check("bp_snap_valid", snap_valid, 1'b1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (rx_ready !== 1'b0 || snap_valid !== 1'b1 || snap !== d) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        check("bp_no_handshake", got_q.size(), 0);
        snap_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_rx_ready_after", rx_ready, 1'b1);
        check("bp_snap_valid_after", snap_valid, 1'b0);
        check("bp_handshake_count", got_q.size(), 1);
        if (got_q.size() > 0) check("bp_snap_data", got_q.pop_front(), d);
        got_q.delete();
        run_frame(rand_data(), 3'b000, 8'h00, 1'b1, 0);

        // Stall timeout: 10 payload bytes, then 1024 idle cycles
        e0 = err_pulses;
        build_frame(rand_data(), 3'b000, 8'h00);
        send_range(0, 10, 0);
        repeat (1023) @(posedge clock);
        #1;
        check("timeout_not_yet", frame_err, 1'b0);
        @(posedge clock);
        #1;
        check("timeout_pulse", frame_err, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("timeout_single_pulse", err_pulses - e0, 1);
        check("timeout_count_kept", frame_count, exp_fc);
        run_frame(rand_data(), 3'b000, 8'h00, 1'b1, 0);

        // Byte arriving on the would-expire cycle keeps the frame alive
        e0 = err_pulses;
        d = rand_data();
        build_frame(d, 3'b000, 8'h00);
        send_range(0, 10, 0);
        repeat (1023) @(posedge clock);
        send_range(11, 28, 0);
        exp_fc    = exp_fc + 1'b1;
        last_good = d;
        check("late_byte_snap_valid", snap_valid, 1'b1);
        check("late_byte_frame_count", frame_count, exp_fc);
        post_frame_checks(d, 1'b1, e0);

        // Reset mid-frame after 14 payload bytes
        e0 = err_pulses;
        build_frame(rand_data(), 3'b000, 8'h00);
        send_range(0, 14, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset_rx_ready", rx_ready, 1'b1);
        check("midreset_snap", snap, '0);
        check("midreset_snap_valid", snap_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_frame_count", frame_count, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        exp_fc    = '0;
        last_good = '0;
        repeat (2) @(posedge clock);
        #1;
        check("midreset_no_err", err_pulses - e0, 0);
        run_frame(rand_data(), 3'b000, 8'h00, 1'b1, 0);

        // frame_count wrap from 16'hFFFF
        @(negedge clock);
        force dut.frame_count_q = 16'hFFFF;
        repeat (2) @(posedge clock);
        @(negedge clock);
        release dut.frame_count_q;
        exp_fc = 16'hFFFF;
        #1;
        check("preload_count", frame_count, 16'hFFFF);
        run_frame(rand_data(), 3'b000, 8'h00, 1'b1, 0);
        check("wrap_count", frame_count, 16'h0000);

        // Randomized frames with random gaps
        for (int n = 0; n < 16; n++) begin
            d     = rand_data();
            pad   = 3'b000;
            delta = 8'h00;
            mode  = $urandom_range(0, 3);
            if (mode == 1) delta = 8'($urandom_range(1, 255));
            if (mode == 2) pad   = 3'($urandom_range(1, 7));
            if (mode == 3) begin
                for (int j = 0; j < 4; j++) d[8*$urandom_range(0, 25) +: 8] = 8'hA5;
            end
            run_frame(d, pad, delta, (delta == 8'h00) && (pad == 3'b000), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
